// File: rtl/hazard_pkg.sv
// Shared types for the forwarding/hazard controller: forward-select codes and
// the shadow pipeline records for the EX, MEM and WB stages.
package hazard_pkg;

    // Register addresses are held zero-extended to this width inside the records.
    localparam int unsigned REG_AW_MAX = 8;

    localparam logic [1:0] FWD_RF    = 2'b00;
    localparam logic [1:0] FWD_EXMEM = 2'b01;
    localparam logic [1:0] FWD_MEMWB = 2'b10;

    typedef struct packed {
        logic                  valid;
        logic [REG_AW_MAX-1:0] rs;
        logic [REG_AW_MAX-1:0] rt;
        logic                  rt_used;
        logic [REG_AW_MAX-1:0] rd;
        logic                  reg_write;
        logic                  mem_read;
        logic                  mem_write;
    } ex_rec_t;

    typedef struct packed {
        logic                  valid;
        logic [REG_AW_MAX-1:0] rt;
        logic [REG_AW_MAX-1:0] rd;
        logic                  reg_write;
        logic                  mem_read;
        logic                  mem_write;
    } mem_rec_t;

    typedef struct packed {
        logic                  valid;
        logic [REG_AW_MAX-1:0] rd;
        logic                  reg_write;
    } wb_rec_t;

endpackage

// File: rtl/hazard_src_match.sv
// Flags a source register that a live producer (valid, writing, rd != $0) is
// about to overwrite.
module hazard_src_match
    import hazard_pkg::*;
(
    input  logic [REG_AW_MAX-1:0] src,
    input  logic [REG_AW_MAX-1:0] prod_rd,
    input  logic                  prod_valid,
    input  logic                  prod_reg_write,
    output logic                  hit_c
);

    assign hit_c = prod_valid && prod_reg_write && (prod_rd != '0) && (prod_rd == src);

endmodule

// File: rtl/hazard_forward_ctrl.sv
// Forwarding and hazard controller for the 5-stage pipeline: shadow EX/MEM/WB
// producer records drive operand forwards, store-data forward and stalls.
// REG_AW must not exceed hazard_pkg::REG_AW_MAX.
module hazard_forward_ctrl
    import hazard_pkg::*;
#(
    parameter int unsigned REG_AW       = 5,
    parameter bit          FWD_EN       = 1'b1,
    parameter bit          RF_WT_BYPASS = 1'b1,
    parameter int unsigned CNT_W        = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              flush,
    input  logic              id_valid,
    input  logic [REG_AW-1:0] id_rs,
    input  logic [REG_AW-1:0] id_rt,
    input  logic              id_rt_used,
    input  logic [REG_AW-1:0] id_rd,
    input  logic              id_reg_write,
    input  logic              id_mem_read,
    input  logic              id_mem_write,
    output logic              stall,
    output logic [1:0]        fwd_a,
    output logic [1:0]        fwd_b,
    output logic              fwd_mem,
    output logic [CNT_W-1:0]  stall_count
);

    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    ex_rec_t          ex_q;
    ex_rec_t          ex_d;
    mem_rec_t         mem_q;
    wb_rec_t          wb_q;
    logic [CNT_W-1:0] cnt_q;

    logic [REG_AW_MAX-1:0] id_rs_x;
    logic [REG_AW_MAX-1:0] id_rt_x;
    assign id_rs_x = REG_AW_MAX'(id_rs);
    assign id_rt_x = REG_AW_MAX'(id_rt);

    // Producer view of the shadow stages: index 0 = EX, 1 = MEM, 2 = WB.
    logic [REG_AW_MAX-1:0] prod_rd [3];
    logic [2:0]            prod_valid;
    logic [2:0]            prod_rw;
    assign prod_rd[0] = ex_q.rd;
    assign prod_rd[1] = mem_q.rd;
    assign prod_rd[2] = wb_q.rd;
    assign prod_valid = {wb_q.valid, mem_q.valid, ex_q.valid};
    assign prod_rw    = {wb_q.reg_write, mem_q.reg_write, ex_q.reg_write};

    logic [2:0] id_rs_hit;
    logic [2:0] id_rt_hit;
    for (genvar s = 0; s < 3; s++) begin : g_id_match
        hazard_src_match u_rs (
            .src            (id_rs_x),
            .prod_rd        (prod_rd[s]),
            .prod_valid     (prod_valid[s]),
            .prod_reg_write (prod_rw[s]),
            .hit_c          (id_rs_hit[s])
        );
        hazard_src_match u_rt (
            .src            (id_rt_x),
            .prod_rd        (prod_rd[s]),
            .prod_valid     (prod_valid[s]),
            .prod_reg_write (prod_rw[s]),
            .hit_c          (id_rt_hit[s])
        );
    end

    // EX operands against the older producers: index 0 = MEM, 1 = WB.
    logic [1:0] ex_rs_hit;
    logic [1:0] ex_rt_hit;
    for (genvar s = 0; s < 2; s++) begin : g_ex_match
        hazard_src_match u_rs (
            .src            (ex_q.rs),
            .prod_rd        (prod_rd[s+1]),
            .prod_valid     (prod_valid[s+1]),
            .prod_reg_write (prod_rw[s+1]),
            .hit_c          (ex_rs_hit[s])
        );
        hazard_src_match u_rt (
            .src            (ex_q.rt),
            .prod_rd        (prod_rd[s+1]),
            .prod_valid     (prod_valid[s+1]),
            .prod_reg_write (prod_rw[s+1]),
            .hit_c          (ex_rt_hit[s])
        );
    end

    logic mem_rt_hit;
    hazard_src_match u_mem_rt (
        .src            (mem_q.rt),
        .prod_rd        (wb_q.rd),
        .prod_valid     (wb_q.valid),
        .prod_reg_write (wb_q.reg_write),
        .hit_c          (mem_rt_hit)
    );

    // Stall decision; a store whose only dependency is its data register rides
    // through and picks the load result up in MEM instead.
    logic rs_ex;
    logic rt_ex;
    logic load_use;
    logic no_fwd_dep;
    always_comb begin
        rs_ex      = id_rs_hit[0];
        rt_ex      = id_rt_used && id_rt_hit[0];
        load_use   = ex_q.mem_read && (rs_ex || rt_ex) && !(id_mem_write && rt_ex && !rs_ex);
        no_fwd_dep = id_rs_hit[0] || id_rs_hit[1] ||
                     (id_rt_used && (id_rt_hit[0] || id_rt_hit[1]));
        if (!RF_WT_BYPASS) begin
            no_fwd_dep = no_fwd_dep || id_rs_hit[2] || (id_rt_used && id_rt_hit[2]);
        end
        stall = id_valid && !flush && (FWD_EN ? load_use : no_fwd_dep);
    end

    // Forward selects; MEM is newer than WB so it wins, but a load in MEM has no data yet.
    always_comb begin
        fwd_a   = FWD_RF;
        fwd_b   = FWD_RF;
        fwd_mem = 1'b0;
        if (FWD_EN) begin
            if (ex_rs_hit[0] && !mem_q.mem_read) begin
                fwd_a = FWD_EXMEM;
            end else if (ex_rs_hit[1]) begin
                fwd_a = FWD_MEMWB;
            end
            if (ex_q.rt_used) begin
                if (ex_rt_hit[0] && !mem_q.mem_read) begin
                    fwd_b = FWD_EXMEM;
                end else if (ex_rt_hit[1]) begin
                    fwd_b = FWD_MEMWB;
                end
            end
            fwd_mem = mem_q.valid && mem_q.mem_write && mem_rt_hit;
        end
    end

    always_comb begin
        ex_d = '0;
        if (id_valid && !flush && !stall) begin
            ex_d.valid     = 1'b1;
            ex_d.rs        = id_rs_x;
            ex_d.rt        = id_rt_x;
            ex_d.rt_used   = id_rt_used;
            ex_d.rd        = REG_AW_MAX'(id_rd);
            ex_d.reg_write = id_reg_write;
            ex_d.mem_read  = id_mem_read;
            ex_d.mem_write = id_mem_write;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            ex_q  <= '0;
            mem_q <= '0;
            wb_q  <= '0;
            cnt_q <= '0;
        end else begin
            ex_q  <= ex_d;
            mem_q <= '{valid:     ex_q.valid,
                       rt:        ex_q.rt,
                       rd:        ex_q.rd,
                       reg_write: ex_q.reg_write,
                       mem_read:  ex_q.mem_read,
                       mem_write: ex_q.mem_write};
            wb_q  <= '{valid: mem_q.valid, rd: mem_q.rd, reg_write: mem_q.reg_write};
            if (stall && (cnt_q != CNT_MAX)) begin
                cnt_q <= cnt_q + CNT_W'(1);
            end
        end
    end

    assign stall_count = cnt_q;

endmodule
